// File: rtl/hamming_test_pkg.sv
// Shared types and constants for the SEC-DED Hamming self-test sequencer.
package hamming_test_pkg;

   localparam int CW_W   = 12;
   localparam int DATA_W = 7;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      APPLY = 3'd1,
      WAIT  = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4
   } state_e;

   localparam logic [1:0] MODE_NONE   = 2'd0;
   localparam logic [1:0] MODE_SINGLE = 2'd1;
   localparam logic [1:0] MODE_DOUBLE = 2'd2;

   localparam logic [1:0] DS_CLEAN  = 2'b00;
   localparam logic [1:0] DS_SINGLE = 2'b01;
   localparam logic [1:0] DS_DOUBLE = 2'b10;

   // Corruption pattern XORed onto the generated codeword for a given mode.
   function automatic logic [CW_W-1:0] flip_mask(input logic [1:0] mode,
                                                 input logic [3:0] p1,
                                                 input logic [3:0] p2);
      logic [CW_W-1:0] m;
      case (mode)
         MODE_NONE:   m = 12'd0;
         MODE_SINGLE: m = 12'd1 << p1;
         MODE_DOUBLE: m = (12'd1 << p1) | (12'd1 << p2);
         default:     m = 12'd0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/hts_err_pos.sv
// Error-position source: 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1) and the
// two derived bit positions p1 and p2 (always distinct, both 0..11).
module hts_err_pos #(
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       advance,
   input  logic       load,
   output logic [3:0] p1,
   output logic [3:0] p2
);

   logic [7:0] lfsr_q;
   logic [7:0] lfsr_d;
   logic [3:0] ofs_s;
   logic [4:0] sum_s;
   logic [4:0] p2_full_s;

   // Next LFSR value: reload has priority over a step.
   always_comb begin
      lfsr_d = lfsr_q;
      if (load) begin
         lfsr_d = LFSR_SEED;
      end else if (advance) begin
         lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
      end else begin
         lfsr_d = lfsr_q;
      end
   end

   // LFSR state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   // Fold the nibbles into range; the 1..11 offset keeps p2 away from p1.
   always_comb begin
      p1        = (lfsr_q[3:0] >= 4'd12) ? (lfsr_q[3:0] - 4'd12) : lfsr_q[3:0];
      ofs_s     = (lfsr_q[7:4] >= 4'd11) ? (lfsr_q[7:4] - 4'd11) : lfsr_q[7:4];
      sum_s     = {1'b0, p1} + 5'd1 + {1'b0, ofs_s};
      p2_full_s = (sum_s >= 5'd12) ? (sum_s - 5'd12) : sum_s;
      p2        = p2_full_s[3:0];
   end

endmodule

// File: rtl/hamming_test_sequencer.sv
// Self-test sequencer for the 7-bit/12-bit SEC-DED Hamming path: sweeps
// data words, injects 0/1/2 bit flips and scores the detector's response.
// Optional build macro HTS_STOP_ON_FAIL_EN ends the sweep at the first
// failing check instead of completing it.
module hamming_test_sequencer
   import hamming_test_pkg::*;
#(
   parameter int         WORD_CNT  = 128,
   parameter int         DET_LAT   = 1,
   parameter logic [7:0] LFSR_SEED = 8'hA5,
   parameter int         CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] gen_data,
   input  logic [CW_W-1:0]   gen_code,
   output logic [CW_W-1:0]   det_code,
   input  logic [CW_W-1:0]   det_data,
   input  logic [1:0]        det_ds,
   output logic [CNT_W-1:0]  pass_cnt,
   output logic [CNT_W-1:0]  fail_cnt,
   output logic [DATA_W-1:0] fail_word,
   output logic [1:0]        fail_mode
);

   localparam logic [DATA_W-1:0] LAST_WORD = DATA_W'(WORD_CNT - 1);
   localparam logic [3:0]        LAT_M1    = 4'((DET_LAT > 0) ? (DET_LAT - 1) : 0);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e            state_q, state_d;
   logic [DATA_W-1:0] word_q, word_d;
   logic [1:0]        mode_q, mode_d;
   logic [3:0]        wait_q, wait_d;
   logic [CW_W-1:0]   det_code_q, det_code_d;
   logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
   logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
   logic [DATA_W-1:0] fail_word_q, fail_word_d;
   logic [1:0]        fail_mode_q, fail_mode_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [3:0]        p1_s, p2_s;
   logic              load_s, advance_s;
   logic              pass_s, stop_s;

   hts_err_pos #(.LFSR_SEED(LFSR_SEED)) u_err_pos (
      .clk     (clk),
      .rst     (rst),
      .advance (advance_s),
      .load    (load_s),
      .p1      (p1_s),
      .p2      (p2_s)
   );

   // Judge the detector response against what the current mode should yield.
   always_comb begin
      pass_s = 1'b0;
      case (mode_q)
         MODE_NONE:   pass_s = (det_ds == DS_CLEAN) && (det_data[DATA_W-1:0] == word_q) &&
                               (det_data[CW_W-1:DATA_W] == {(CW_W-DATA_W){1'b0}});
         MODE_SINGLE: pass_s = (det_ds == DS_SINGLE) && (det_data[DATA_W-1:0] == word_q);
         MODE_DOUBLE: pass_s = (det_ds == DS_DOUBLE);
         default:     pass_s = 1'b0;
      endcase
`ifdef HTS_STOP_ON_FAIL_EN
      stop_s = !pass_s;
`else
      stop_s = 1'b0;
`endif
   end

   // Next-state, corruption datapath and scoreboard counter updates.
   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      mode_d      = mode_q;
      wait_d      = wait_q;
      det_code_d  = det_code_q;
      pass_cnt_d  = pass_cnt_q;
      fail_cnt_d  = fail_cnt_q;
      fail_word_d = fail_word_q;
      fail_mode_d = fail_mode_q;
      load_s      = 1'b0;
      advance_s   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = APPLY;
               word_d      = {DATA_W{1'b0}};
               mode_d      = MODE_NONE;
               pass_cnt_d  = {CNT_W{1'b0}};
               fail_cnt_d  = {CNT_W{1'b0}};
               fail_word_d = {DATA_W{1'b0}};
               fail_mode_d = MODE_NONE;
               load_s      = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         APPLY: begin
            det_code_d = gen_code ^ flip_mask(mode_q, p1_s, p2_s);
            if (DET_LAT > 0) begin
               state_d = WAIT;
               wait_d  = LAT_M1;
            end else begin
               state_d = CHECK;
            end
         end
         WAIT: begin
            if (wait_q == 4'd0) begin
               state_d = CHECK;
            end else begin
               wait_d = wait_q - 4'd1;
            end
         end
         CHECK: begin
            advance_s = 1'b1;
            if (pass_s) begin
               pass_cnt_d = (pass_cnt_q != CNT_MAX) ? (pass_cnt_q + CNT_ONE) : pass_cnt_q;
            end else begin
               fail_cnt_d  = (fail_cnt_q != CNT_MAX) ? (fail_cnt_q + CNT_ONE) : fail_cnt_q;
               fail_word_d = word_q;
               fail_mode_d = mode_q;
            end
            if (stop_s) begin
               state_d = DONE;
            end else if (mode_q != MODE_DOUBLE) begin
               mode_d  = mode_q + 2'd1;
               state_d = APPLY;
            end else begin
               mode_d = MODE_NONE;
               if (word_q == LAST_WORD) begin
                  state_d = DONE;
               end else begin
                  word_d  = word_q + 7'd1;
                  state_d = APPLY;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE) && (state_d != DONE);
      done_d = (state_d == DONE);
   end

   // Controller state and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         word_q      <= {DATA_W{1'b0}};
         mode_q      <= MODE_NONE;
         wait_q      <= 4'd0;
         det_code_q  <= {CW_W{1'b0}};
         pass_cnt_q  <= {CNT_W{1'b0}};
         fail_cnt_q  <= {CNT_W{1'b0}};
         fail_word_q <= {DATA_W{1'b0}};
         fail_mode_q <= MODE_NONE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         mode_q      <= mode_d;
         wait_q      <= wait_d;
         det_code_q  <= det_code_d;
         pass_cnt_q  <= pass_cnt_d;
         fail_cnt_q  <= fail_cnt_d;
         fail_word_q <= fail_word_d;
         fail_mode_q <= fail_mode_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign gen_data  = word_q;
   assign det_code  = det_code_q;
   assign pass_cnt  = pass_cnt_q;
   assign fail_cnt  = fail_cnt_q;
   assign fail_word = fail_word_q;
   assign fail_mode = fail_mode_q;

endmodule

// File: tb/tb_hamming_test_sequencer.sv
// Bench for hamming_test_sequencer: reference SEC-DED generator/detector
// models feed two instances (default sweep, and a short zero-latency one).
module tb_hamming_test_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic dbl_fault;

   // Instance A: WORD_CNT=128, DET_LAT=1
   logic        start_a, busy_a, done_a;
   logic [6:0]  gen_data_a, fw_a;
   logic [11:0] gen_code_a, det_code_a, det_data_a;
   logic [1:0]  det_ds_a, fm_a;
   logic [15:0] pass_a, fail_a;

   // Instance B: WORD_CNT=4, DET_LAT=0
   logic        start_b, busy_b, done_b;
   logic [6:0]  gen_data_b, fw_b;
   logic [11:0] gen_code_b, det_code_b, det_data_b;
   logic [1:0]  det_ds_b, fm_b;
   logic [15:0] pass_b, fail_b;

   int total = 0;
   int bad   = 0;

   // Syndrome column of each data bit (distinct, weight >= 2).
   function automatic logic [3:0] col(input int i);
      case (i)
         0: return 4'd3;
         1: return 4'd5;
         2: return 4'd6;
         3: return 4'd7;
         4: return 4'd9;
         5: return 4'd10;
         default: return 4'd11;
      endcase
   endfunction

   function automatic logic [3:0] chkbits(input logic [6:0] d);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < 7; i++) if (d[i]) c = c ^ col(i);
      return c;
   endfunction

   // Codeword layout: [6:0] data, [10:7] check bits, [11] overall parity.
   function automatic logic [11:0] enc(input logic [6:0] d);
      logic [3:0] c;
      c = chkbits(d);
      return {^{c, d}, c, d};
   endfunction

   // Returns {ds, data12}; dbl_bug makes double errors look clean.
   function automatic logic [13:0] dec(input logic [11:0] cw, input logic dbl_bug);
      logic [6:0] d;
      logic [3:0] s;
      logic [1:0] ds;
      d = cw[6:0];
      s = chkbits(d) ^ cw[10:7];
      if (!(^cw) && s == 4'd0) begin
         ds = 2'b00;
      end else if (^cw) begin
         ds = 2'b01;
         for (int i = 0; i < 7; i++) if (col(i) == s) d[i] = ~d[i];
      end else begin
         ds = dbl_bug ? 2'b00 : 2'b10;
      end
      return {ds, 5'd0, d};
   endfunction

   function automatic logic [7:0] lfsr_step(input logic [7:0] l);
      return {1'b0, l[7:1]} ^ (l[0] ? 8'hB8 : 8'h00);
   endfunction

   function automatic logic [11:0] exp_mask(input int mode, input logic [7:0] l);
      int p1, o, p2;
      p1 = int'(l[3:0]);
      if (p1 >= 12) p1 = p1 - 12;
      o = int'(l[7:4]);
      if (o >= 11) o = o - 11;
      p2 = (p1 + 1 + o) % 12;
      if (mode == 0) return 12'd0;
      else if (mode == 1) return 12'd1 << p1;
      else return (12'd1 << p1) | (12'd1 << p2);
   endfunction

   assign gen_code_a = enc(gen_data_a);
   assign {det_ds_a, det_data_a} = dec(det_code_a, dbl_fault);
   assign gen_code_b = enc(gen_data_b);
   assign {det_ds_b, det_data_b} = dec(det_code_b, 1'b0);

   hamming_test_sequencer #(.WORD_CNT(128), .DET_LAT(1), .LFSR_SEED(8'hA5), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
      .gen_data(gen_data_a), .gen_code(gen_code_a), .det_code(det_code_a),
      .det_data(det_data_a), .det_ds(det_ds_a), .pass_cnt(pass_a), .fail_cnt(fail_a),
      .fail_word(fw_a), .fail_mode(fm_a)
   );

   hamming_test_sequencer #(.WORD_CNT(4), .DET_LAT(0), .LFSR_SEED(8'hA5), .CNT_W(16)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
      .gen_data(gen_data_b), .gen_code(gen_code_b), .det_code(det_code_b),
      .det_data(det_data_b), .det_ds(det_ds_b), .pass_cnt(pass_b), .fail_cnt(fail_b),
      .fail_word(fw_b), .fail_mode(fm_b)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start on A, then count edges until done (bounded) and busy samples.
   task automatic sweep_a(input bit repulse, output int lat, output int busy_n);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      lat = 0;
      busy_n = 0;
      while (done_a !== 1'b1 && lat < 3000) begin
         if (busy_a === 1'b1) busy_n++;
         start_a = repulse && (lat == 300);
         tick();
         lat++;
      end
      start_a = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, busy_n;
      logic [7:0] l;
      logic [11:0] expc;
      rst = 1'b0; start_a = 1'b0; start_b = 1'b0; dbl_fault = 1'b0;
      #12;
      check_val("rst_busy", busy_a, 0);
      check_val("rst_done", done_a, 0);
      check_val("rst_gen_data", gen_data_a, 0);
      check_val("rst_det_code", det_code_a, 0);
      check_val("rst_pass", pass_a, 0);
      check_val("rst_fail", fail_a, 0);
      check_val("rst_fail_word", fw_a, 0);
      check_val("rst_fail_mode", fm_a, 0);
      tick();
      rst = 1'b1;
      tick();

      // Ideal full sweep: 384 checks x 3 cycles; busy drops as done rises.
      sweep_a(1'b0, lat, busy_n);
      check_val("full_latency", lat, 1152);
      check_val("full_busy_cycles", busy_n, 1152);
      check_val("full_busy_in_done", busy_a, 0);
      check_val("full_pass", pass_a, 384);
      check_val("full_fail", fail_a, 0);
      tick();
      check_val("done_one_cycle", done_a, 0);
      repeat (5) tick();
      check_val("hold_pass", pass_a, 384);

      // Detector blind to double errors: every mode-2 check fails.
      dbl_fault = 1'b1;
      sweep_a(1'b0, lat, busy_n);
      check_val("dbl_latency", lat, 1152);
      check_val("dbl_pass", pass_a, 256);
      check_val("dbl_fail", fail_a, 128);
      check_val("dbl_fail_word", fw_a, 127);
      check_val("dbl_fail_mode", fm_a, 2);
      dbl_fault = 1'b0;
      tick();

      // Short zero-latency sweep with exact corruption pattern per check.
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      l = 8'hA5;
      for (int k = 0; k < 12; k++) begin
         tick();
         expc = enc(7'(k / 3)) ^ exp_mask(k % 3, l);
         check_val($sformatf("b_gen_data_%0d", k), gen_data_b, k / 3);
         check_val($sformatf("b_det_code_%0d", k), det_code_b, expc);
         if (k % 3 == 2) check_val($sformatf("b_two_flips_%0d", k), $countones(det_code_b ^ gen_code_b), 2);
         l = lfsr_step(l);
         tick();
      end
      check_val("b_done_at_24", done_b, 1);
      check_val("b_pass", pass_b, 12);
      check_val("b_fail", fail_b, 0);

      // Asynchronous reset mid-sweep, then a clean rerun.
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      repeat (499) tick();
      check_val("pre_reset_pass", pass_a, 166);
      #3;
      rst = 1'b0;
      #1;
      check_val("async_busy", busy_a, 0);
      check_val("async_pass", pass_a, 0);
      check_val("async_det_code", det_code_a, 0);
      check_val("async_gen_data", gen_data_a, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check_val("no_done_in_reset", done_a, 0);
      end
      rst = 1'b1;
      tick();
      check_val("no_done_after_reset", done_a, 0);
      sweep_a(1'b0, lat, busy_n);
      check_val("rerun_latency", lat, 1152);
      check_val("rerun_pass", pass_a, 384);
      check_val("rerun_fail", fail_a, 0);

      // start pulsed mid-sweep and again in the DONE cycle: both ignored.
      tick();
      sweep_a(1'b1, lat, busy_n);
      check_val("repulse_latency", lat, 1152);
      check_val("repulse_pass", pass_a, 384);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      check_val("start_in_done_busy", busy_a, 0);
      check_val("start_in_done_pass", pass_a, 384);
      tick();
      check_val("start_in_done_idle", busy_a, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
